int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller that sits between external device interrupt lines and the coprocessor-0 hardware-interrupt input (6-bit HWInt).
- Synchronises device lines and latches edge-mode requests into pending bits.
- Drives the enabled pending vector to CP0 and tracks the source currently in service from CP0 acceptance until eret.
- Software configures it through a small word-addressed register window on the system bridge.

Parameters:
N_SRC, 6, number of interrupt sources; must be ≤ 6 (width of CP0 HWInt).
ID_W, 3, width of source-id fields (must satisfy 2^ID_W ≥ N_SRC).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq_in  input  N_SRC  raw device interrupt lines, asynchronous
addr  input  2  register word select (0..3)
we  input  1  register write strobe
wdata  input  32  register write data
rdata  output  32  register read data (combinational from addr)
int_taken  input  1  one-cycle pulse: CP0 accepted an interrupt (not an exception) this cycle
eret  input  1  one-cycle pulse: eret executed (EXL clear)
hwint  output  6  to CP0 HWInt; bits ≥ N_SRC tied 0
svc_active  output  1  a source is in service

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous, active-high.
- Reset values: ENABLE=0, MODE=0, edge-pending=0, sync flops=0, prev flops=0, state=IDLE, svc_id=0. Therefore hwint=0 and svc_active=0.
- Input sync: irq_in passes through a 2-flop synchroniser to give s_irq (see Optional Feature).
  - Edge detection uses prev = s_irq delayed one cycle.
  - rise = s_irq & ~prev.
- Pending, per source i:
  - MODE[i]=0 (level): pend[i] = s_irq[i], combinational, not latched.
  - MODE[i]=1 (edge): epend[i] is set on rise[i].
  - epend[i] is cleared by a write of 1 to PENDING bit i, or automatically in the cycle int_taken captures i.
  - Set and clear in the same cycle: set wins.
- hwint = pend & ENABLE, zero-extended to 6 bits.
- Latency: a level raised on irq_in appears on hwint 2 cycles after the first sampling edge (3 cycles for edge mode via prev).
- Registers (addr):
  - 0 ENABLE[N_SRC-1:0]: read/write.
  - 1 MODE[N_SRC-1:0]: read/write. A mode change does not clear epend.
  - 2 PENDING: read returns pend. Write is W1C on edge-mode bits only; level bits are ignored.
  - 3 STATUS: read-only, {svc_active at bit31, svc_id at [ID_W-1:0]}. Writes ignored.
  - Unused read bits return 0.
- FSM, two states:
  - IDLE --int_taken & |hwint--> SERVICE. Captures svc_id = lowest-index set bit of hwint (index 0 highest priority) and auto-clears that epend.
  - IDLE --int_taken & hwint==0--> stay IDLE (spurious accept, no capture).
  - SERVICE --eret--> IDLE. svc_id is held for readback.
  - SERVICE --int_taken--> ignored (no nesting; CP0 EXL normally prevents it). Remain SERVICE with svc_id unchanged.
  - int_taken and eret in the same cycle: in SERVICE, eret wins (→ IDLE, no capture). In IDLE, int_taken is processed and eret is ignored.
- svc_active = (state == SERVICE).
- hwint keeps reporting pending sources during SERVICE; masking is CP0's job.
- Reset asserted in any state returns to reset values on the next edge. It overrides simultaneous we/int_taken.

Optional Feature:
- Macro: INT_CTRL_SYNC2_EN.
- Defined: 2-flop synchroniser as above.
- Undefined: single register stage, so s_irq = irq_in delayed 1 cycle and every latency above drops by 1.
- Register and FSM behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - register offsets (INT_ENABLE=0, INT_MODE=1, INT_PENDING=2, INT_STATUS=3);
  - FSM state encodings (ST_IDLE, ST_SERVICE);
  - STATUS bit positions;
  - the CP0 HWInt width constant (6).
- One natural sub-module: int_prio_enc (N_SRC-bit vector → valid + lowest-set index). It is reused by the arbiter logic.

Test Plan:
- Level source: ENABLE=0x04, MODE=0; hold irq_in[2]=1 → hwint=0x04 two cycles later. Drop irq_in[2] → hwint=0 two cycles later.
- Edge latch with W1C: MODE=0x01, ENABLE=0x01; 1-cycle pulse on irq_in[0] → hwint stays 0x01 after the pulse. Write PENDING=0x01 → hwint=0 next cycle. Write 0x01 with a new rising edge in the same cycle → bit stays set.
- Priority capture: edge sources 1 and 3 both pending, ENABLE=0x0A; pulse int_taken → STATUS reads 0x8000_0001. epend[1] is cleared, hwint=0x08.
- eret: in SERVICE pulse eret → STATUS=0x0000_0001 (id held, bit31=0). Then int_taken → captures id 3, STATUS=0x8000_0003.
- Simultaneous events: in SERVICE assert int_taken+eret together → IDLE, no capture. In IDLE, int_taken with hwint=0 → stays IDLE.
- Reset mid-service: SERVICE with epend=0x3F, ENABLE=0x3F, assert reset one cycle → hwint=0, STATUS=0, ENABLE/MODE read 0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, FSM encoding and field positions shared by the interrupt controller
package int_ctrl_pkg;
    localparam int HWINT_W = 6;
    localparam logic [1:0] INT_ENABLE  = 2'd0;
    localparam logic [1:0] INT_MODE    = 2'd1;
    localparam logic [1:0] INT_PENDING = 2'd2;
    localparam logic [1:0] INT_STATUS  = 2'd3;
    localparam int STAT_ACTIVE_BIT = 31;
    localparam int STAT_ID_LSB     = 0;
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } int_state_e;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: register window and CP0 handshake between the CPU side and the interrupt controller
interface int_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_taken;
    logic        eret;
    logic [5:0]  hwint;
    logic        svc_active;
    modport master (output addr, we, wdata, int_taken, eret, input rdata, hwint, svc_active);
    modport slave  (input addr, we, wdata, int_taken, eret, output rdata, hwint, svc_active);
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-set-bit priority encoder (bit 0 wins)
module int_prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [W-1:0] idx
);
    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid = |vec;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
    end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding CP0 HWInt; define INT_CTRL_SYNC2_EN for a 2-flop input synchroniser
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input logic             clk,
    input logic             reset,
    input logic [N_SRC-1:0] irq_in,
    int_ctrl_if.slave       bus
);
    logic [N_SRC-1:0] en_q, en_d, mode_q, mode_d, epend_q, epend_d;
    logic [N_SRC-1:0] s_irq_q, prev_q, rise, pend, hw, w1c, take_mask;
    logic [ID_W-1:0]  svc_id_q, svc_id_d, enc_idx;
    logic             enc_valid, take;
    logic [31:0]      status;
    int_state_e       state_q, state_d;
`ifdef INT_CTRL_SYNC2_EN
    logic [N_SRC-1:0] sync1_q;
`endif

    int_prio_enc #(.N(N_SRC), .W(ID_W)) u_enc (
        .vec   (hw),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Pending vector, register updates and accept/eret tracking
    always_comb begin
        rise = s_irq_q & ~prev_q;
        pend = (mode_q & epend_q) | (~mode_q & s_irq_q);
        hw = pend & en_q;
        take = state_q == ST_IDLE && bus.int_taken && enc_valid;
        take_mask = take ? N_SRC'(1) << enc_idx : '0;
        w1c = (bus.we && bus.addr == INT_PENDING) ? bus.wdata[N_SRC-1:0] & mode_q : '0;
        en_d = (bus.we && bus.addr == INT_ENABLE) ? bus.wdata[N_SRC-1:0] : en_q;
        mode_d = (bus.we && bus.addr == INT_MODE) ? bus.wdata[N_SRC-1:0] : mode_q;
        epend_d = (epend_q & ~(w1c | take_mask)) | (rise & mode_q);
        state_d = state_q == ST_SERVICE ? (bus.eret ? ST_IDLE : ST_SERVICE)
                                        : (take ? ST_SERVICE : ST_IDLE);
        svc_id_d = take ? enc_idx : svc_id_q;
    end

    // Register readback and CP0-facing outputs
    always_comb begin
        status = '0;
        status[STAT_ACTIVE_BIT] = state_q == ST_SERVICE;
        status[STAT_ID_LSB +: ID_W] = svc_id_q;
        bus.hwint = HWINT_W'(hw);
        bus.svc_active = state_q == ST_SERVICE;
        bus.rdata = bus.addr == INT_ENABLE  ? 32'(en_q)   :
                    bus.addr == INT_MODE    ? 32'(mode_q) :
                    bus.addr == INT_PENDING ? 32'(pend)   : status;
    end

    // All state: synchroniser, edge history, config, edge-pending and service FSM
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef INT_CTRL_SYNC2_EN
            sync1_q <= '0;
`endif
            s_irq_q <= '0;
            prev_q <= '0;
            en_q <= '0;
            mode_q <= '0;
            epend_q <= '0;
            state_q <= ST_IDLE;
            svc_id_q <= '0;
        end else begin
`ifdef INT_CTRL_SYNC2_EN
            sync1_q <= irq_in;
            s_irq_q <= sync1_q;
`else
            s_irq_q <= irq_in;
`endif
            prev_q <= s_irq_q;
            en_q <= en_d;
            mode_q <= mode_d;
            epend_q <= epend_d;
            state_q <= state_d;
            svc_id_q <= svc_id_d;
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
`ifdef INT_CTRL_SYNC2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic       clk = 0;
    logic       reset = 1;
    logic [5:0] irq_in = '0;
    int n_cmp = 0;
    int n_err = 0;

    int_ctrl_if bus ();

    int_ctrl #(.N_SRC(6), .ID_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.wdata = d;
        bus.we = 1;
        @(negedge clk);
        bus.we = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_taken(input logic with_eret);
        bus.int_taken = 1;
        bus.eret = with_eret;
        @(negedge clk);
        bus.int_taken = 0;
        bus.eret = 0;
    endtask

    task automatic pulse_eret;
        bus.eret = 1;
        @(negedge clk);
        bus.eret = 0;
    endtask

    task automatic pulse_irq(input logic [5:0] v);
        irq_in = v;
        @(negedge clk);
        irq_in = '0;
        cycles(LAT);
    endtask

    initial begin
        bus.addr = 0;
        bus.we = 0;
        bus.wdata = 0;
        bus.int_taken = 0;
        bus.eret = 0;
        cycles(3);
        reset = 0;
        // reset state
        chk("rst_hwint", 32'(bus.hwint), 0);
        chk("rst_svc", 32'(bus.svc_active), 0);
        rd("rst_enable", 0, 0);
        rd("rst_mode", 1, 0);
        rd("rst_pending", 2, 0);
        rd("rst_status", 3, 0);
        // level source
        wr(0, 32'h04);
        irq_in = 6'h04;
        cycles(LAT);
        chk("lvl_on", 32'(bus.hwint), 32'h04);
        rd("lvl_pend_rd", 2, 32'h04);
        wr(2, 32'h04);
        chk("lvl_w1c_ignored", 32'(bus.hwint), 32'h04);
        irq_in = 0;
        cycles(LAT);
        chk("lvl_off", 32'(bus.hwint), 0);
        // edge latch and W1C
        wr(1, 32'h01);
        wr(0, 32'h01);
        pulse_irq(6'h01);
        chk("edge_latched", 32'(bus.hwint), 32'h01);
        cycles(3);
        chk("edge_held", 32'(bus.hwint), 32'h01);
        wr(2, 32'h01);
        chk("edge_w1c", 32'(bus.hwint), 0);
        irq_in = 6'h01;
        cycles(LAT);
        wr(2, 32'h01);
        chk("edge_set_wins", 32'(bus.hwint), 32'h01);
        irq_in = 0;
        wr(2, 32'h01);
        chk("edge_w1c2", 32'(bus.hwint), 0);
        // priority capture
        wr(1, 32'h0A);
        wr(0, 32'h0A);
        pulse_irq(6'h0A);
        chk("prio_pend", 32'(bus.hwint), 32'h0A);
        pulse_taken(0);
        rd("prio_status", 3, 32'h8000_0001);
        chk("prio_hwint", 32'(bus.hwint), 32'h08);
        chk("prio_svc", 32'(bus.svc_active), 1);
        // eret then second capture
        pulse_eret();
        rd("eret_status", 3, 32'h0000_0001);
        pulse_taken(0);
        rd("cap3_status", 3, 32'h8000_0003);
        chk("cap3_hwint", 32'(bus.hwint), 0);
        // no nesting while in service
        pulse_irq(6'h02);
        chk("nest_pend", 32'(bus.hwint), 32'h02);
        pulse_taken(0);
        rd("nest_status", 3, 32'h8000_0003);
        chk("nest_hwint", 32'(bus.hwint), 32'h02);
        // int_taken + eret in SERVICE: eret wins
        pulse_taken(1);
        rd("both_svc_status", 3, 32'h0000_0003);
        chk("both_svc_hwint", 32'(bus.hwint), 32'h02);
        // int_taken + eret in IDLE: take processed
        pulse_taken(1);
        rd("both_idle_status", 3, 32'h8000_0001);
        pulse_eret();
        // spurious accept with nothing pending
        chk("spur_hwint", 32'(bus.hwint), 0);
        pulse_taken(0);
        rd("spur_status", 3, 32'h0000_0001);
        // reset mid-service, overriding a write and an accept
        wr(1, 32'h3F);
        wr(0, 32'h3F);
        pulse_irq(6'h3F);
        chk("all_pend", 32'(bus.hwint), 32'h3F);
        pulse_taken(0);
        rd("all_status", 3, 32'h8000_0000);
        chk("all_hwint", 32'(bus.hwint), 32'h3E);
        reset = 1;
        bus.addr = 0;
        bus.wdata = 32'h3F;
        bus.we = 1;
        bus.int_taken = 1;
        @(negedge clk);
        reset = 0;
        bus.we = 0;
        bus.int_taken = 0;
        chk("rst2_hwint", 32'(bus.hwint), 0);
        chk("rst2_svc", 32'(bus.svc_active), 0);
        rd("rst2_status", 3, 0);
        rd("rst2_enable", 0, 0);
        rd("rst2_mode", 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
